retire_rob: RTL and testbench
=============================

// Module: retire_rob
// PURPOSE
//  In-order reorder buffer feeding commit_stage. Accepts one issued instruction/cycle,
//  tags it with trans_id = slot index, absorbs out-of-order FU writebacks, and presents
//  the oldest NR_COMMIT_PORTS entries as commit_instr_o. Retires entries on commit_ack_i.
//  Sits between issue_stage/ex_stage writeback buses and commit_stage.
// PARAMETERS
//  NR_ENTRIES       8  ROB depth; power of 2, >= NR_COMMIT_PORTS; $clog2(NR_ENTRIES) == TRANS_ID_BITS
//  NR_WB_PORTS      4  FU writeback ports
//  NR_COMMIT_PORTS  2  commit ports presented to commit_stage
// PORTS
//  clk_i            in   1                            clock
//  rst_i            in   1                            sync reset, active-high
//  flush_i          in   1                            discard all entries (mispredict/exception)
//  issue_valid_i    in   1                            issue request
//  issue_ready_o    out  1                            slot free; issue accepted when valid&ready
//  issue_instr_i    in   scoreboard_entry_t           decoded instr (pc, fu, op, rd, ex)
//  issue_trans_id_o out  TRANS_ID_BITS                trans_id assigned to current issue (= tail)
//  wb_valid_i       in   NR_WB_PORTS                  writeback valid per port
//  wb_trans_id_i    in   NR_WB_PORTS x TRANS_ID_BITS  target entry
//  wb_data_i        in   NR_WB_PORTS x XLEN           result
//  wb_ex_i          in   NR_WB_PORTS x exception_t    FU exception
//  commit_instr_o   out  NR_COMMIT_PORTS x scoreboard_entry_t  head..head+N-1; .valid = present & done
//  commit_ack_i     in   NR_COMMIT_PORTS              retire; must be a prefix (ack[i] => ack[i-1])
//  rob_empty_o      out  1                            no entries held
// BEHAVIOUR
//  - Storage: per slot {entry, present, done}; head/tail ptrs TRANS_ID_BITS wide, wrap mod
//    NR_ENTRIES; count $clog2(NR_ENTRIES)+1 bits, 0..NR_ENTRIES.
//  - Reset (rst_i=1 at clk edge): head=tail=count=0, all present/done=0. Outputs after reset:
//    issue_ready_o=1, issue_trans_id_o=0, rob_empty_o=1, all commit_instr_o[i].valid=0.
//  - Issue: issue_ready_o = (count != NR_ENTRIES), from registered count only; a commit in the
//    same cycle does NOT free a slot for issue (no bypass). On accept: slot[tail] <= instr,
//    present=1, done=issue_instr_i.ex.valid (faulting instr needs no writeback), tail++.
//  - Writeback: for each wb_valid_i[k] with slot present: result <= wb_data_i[k]; if
//    wb_ex_i[k].valid, ex <= wb_ex_i[k]; done <= 1. WB to non-present slot ignored.
//    Two ports hitting one trans_id same cycle is illegal (assertion); higher k wins.
//  - Latency: issue or WB at edge N -> visible on commit_instr_o after edge N (1 cycle).
//    No combinational path wb_* -> commit_instr_o or commit_ack_i -> any output.
//  - Commit: commit_instr_o[i] = slot[head+i] (wrapping), .valid = present & done &
//    all lower ports valid (in-order prefix). On edge: pop P = popcount(commit_ack_i & valid);
//    clear present/done of those slots, head += P, count += accept - P.
//    ack on invalid port ignored + assertion. ack[i] without ack[i-1] illegal (assertion).
//  - Full + commit same cycle: ready=0 that cycle; ready=1 the next.
//  - Empty: rob_empty_o = (count==0); ack ignored.
//  - flush_i: highest priority over issue/WB/ack in that cycle; same next-state as reset
//    (ptrs to 0, present/done cleared). rst_i dominates flush_i.
//  - Reset mid-operation: all in-flight entries lost, no retire; FUs are reset in lockstep.
// STRUCTURE
//  - ariane_pkg: scoreboard_entry_t, exception_t, TRANS_ID_BITS (existing); add
//    rob_slot_t {scoreboard_entry_t sbe; logic present; logic done;}.
//  - Single module; optional sub-module rob_wb_match (per-slot one-hot WB port select,
//    NR_WB_PORTS x NR_ENTRIES comparators + priority). No other hierarchy.
// TESTING
//  1 Reset: rst_i 1 cycle -> issue_ready_o=1, issue_trans_id_o=0, rob_empty_o=1, no commit valid.
//  2 OoO WB: issue A,B,C (ids 0,1,2); WB id2=0x33, id1=0x22, then id0=0x11 -> commit valid only
//    after id0 WB; ports show A=0x11,B=0x22; ack 2'b11 -> head=2, C valid with 0x33.
//  3 Full/wrap (NR_ENTRIES=8): issue 8 -> ready=0; WB+ack id0 same cycle as issue attempt ->
//    issue rejected, accepted next cycle with trans_id 0; head wraps 7->0 correctly.
//  4 Issue-time exception: issue instr with ex.valid=1, cause=2 -> next cycle commit_instr_o[0]
//    valid with ex.cause=2, no WB needed; WB with wb_ex.valid cause=5 overrides earlier ex.
//  5 Flush: 5 entries, WB and ack asserted with flush_i -> nothing retired, rob_empty_o=1,
//    issue_trans_id_o=0 next cycle; stale WB to id3 afterwards ignored.
//  6 Prefix commit: head done, head+1 not done -> only port0 valid; ack 2'b01 -> count-1.

Source files
------------

// File: rtl/retire_rob_pkg.sv
// Shared types for the retire reorder buffer.
//   exception_t        : exception cause/tval with valid flag
//   scoreboard_entry_t : decoded instruction as tracked from issue to commit
//   rob_slot_t         : one ROB storage slot {entry, present, done}
package retire_rob_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_MUL,
    FU_LOAD,
    FU_STORE,
    FU_BRANCH
  } fu_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [7:0]               op;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              present;
    logic              done;
  } rob_slot_t;

endpackage

// File: rtl/retire_rob_wb_match.sv
// Writeback-to-slot matcher.
// For every ROB slot, reports whether any writeback port targets it this
// cycle and which port; when several ports hit one slot the highest index wins.
//   wb_valid    : per-port writeback valid
//   wb_trans_id : per-port target slot
//   slot_hit    : per-slot hit flag
//   slot_port   : per-slot winning port index
module retire_rob_wb_match
  import retire_rob_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = 8,
  parameter int unsigned NR_WB_PORTS = 4,
  parameter int unsigned PORT_W      = 2
) (
  input  logic [NR_WB_PORTS-1:0]                    wb_valid,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id,
  output logic [NR_ENTRIES-1:0]                     slot_hit,
  output logic [NR_ENTRIES-1:0][PORT_W-1:0]         slot_port
);

  always_comb begin
    slot_hit  = '0;
    slot_port = '0;
    for (int s = 0; s < NR_ENTRIES; s++) begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (wb_valid[k] && (wb_trans_id[k] == TRANS_ID_BITS'(s))) begin
          slot_hit[s]  = 1'b1;
          slot_port[s] = PORT_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/retire_rob.sv
// In-order reorder buffer between issue/writeback and commit.
// Accepts one instruction per cycle tagged with trans_id = tail slot, absorbs
// out-of-order FU writebacks, presents the oldest NR_COMMIT_PORTS entries to
// commit and retires them on commit_ack_i.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : drop every entry (overrides issue/writeback/ack)
//   issue_*           : issue handshake, instruction and assigned trans_id
//   wb_*              : NR_WB_PORTS writeback buses (valid, id, data, exception)
//   commit_instr_o    : head..head+N-1, .valid = present & done & lower ports valid
//   commit_ack_i      : retire request, prefix of the commit ports
//   rob_empty_o       : no entries held
module retire_rob
  import retire_rob_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic                                      issue_valid_i,
  output logic                                      issue_ready_o,
  input  scoreboard_entry_t                         issue_instr_i,
  output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
  output logic                                      rob_empty_o
);

  localparam int unsigned CNT_W  = TRANS_ID_BITS + 1;
  localparam int unsigned PORT_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  rob_slot_t                   slots_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0]    head_q;
  logic [TRANS_ID_BITS-1:0]    tail_q;
  logic [CNT_W-1:0]            count_q;

  logic                        issue_fire;
  scoreboard_entry_t           issue_sbe;
  logic [NR_ENTRIES-1:0]       wb_hit;
  logic [NR_ENTRIES-1:0][PORT_W-1:0] wb_port;
  logic [TRANS_ID_BITS-1:0]    commit_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0]  commit_valid;
  logic [NR_COMMIT_PORTS-1:0]  ack_eff;
  logic [CNT_W-1:0]            pop_cnt;
  logic                        prefix_ok;

  // Ready comes from the registered count only; a same-cycle retire does not free a slot.
  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_fire       = issue_valid_i && issue_ready_o;
  assign issue_trans_id_o = tail_q;
  assign rob_empty_o      = (count_q == '0);

  always_comb begin
    issue_sbe          = issue_instr_i;
    issue_sbe.trans_id = tail_q;
    issue_sbe.valid    = 1'b0;
  end

  retire_rob_wb_match #(
    .NR_ENTRIES (NR_ENTRIES),
    .NR_WB_PORTS(NR_WB_PORTS),
    .PORT_W     (PORT_W)
  ) u_wb_match (
    .wb_valid   (wb_valid_i),
    .wb_trans_id(wb_trans_id_i),
    .slot_hit   (wb_hit),
    .slot_port  (wb_port)
  );

  // Commit view is taken purely from registered slot state.
  always_comb begin
    prefix_ok = 1'b1;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      commit_idx[i]           = head_q + TRANS_ID_BITS'(i);
      commit_valid[i]         = prefix_ok && slots_q[commit_idx[i]].present
                                && slots_q[commit_idx[i]].done;
      prefix_ok               = commit_valid[i];
      commit_instr_o[i]       = slots_q[commit_idx[i]].sbe;
      commit_instr_o[i].valid = commit_valid[i];
    end
  end

  assign ack_eff = commit_ack_i & commit_valid;
  assign pop_cnt = CNT_W'($countones(ack_eff));

  // Register stage: slot state, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < NR_ENTRIES; s++) begin
        slots_q[s].present <= 1'b0;
        slots_q[s].done    <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NR_ENTRIES; s++) begin
        if (wb_hit[s] && slots_q[s].present) begin
          slots_q[s].sbe.result <= wb_data_i[wb_port[s]];
          if (wb_ex_i[wb_port[s]].valid) begin
            slots_q[s].sbe.ex <= wb_ex_i[wb_port[s]];
          end
          slots_q[s].done <= 1'b1;
        end
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (ack_eff[i]) begin
          slots_q[commit_idx[i]].present <= 1'b0;
          slots_q[commit_idx[i]].done    <= 1'b0;
        end
      end
      // An instruction that faulted at issue needs no writeback to commit.
      if (issue_fire) begin
        slots_q[tail_q].sbe     <= issue_sbe;
        slots_q[tail_q].present <= 1'b1;
        slots_q[tail_q].done    <= issue_instr_i.ex.valid;
      end
      head_q  <= head_q + TRANS_ID_BITS'(pop_cnt);
      tail_q  <= tail_q + TRANS_ID_BITS'(issue_fire);
      count_q <= count_q + CNT_W'(issue_fire) - pop_cnt;
    end
  end

  for (genvar i = 1; i < NR_COMMIT_PORTS; i++) begin : g_ack_prefix
    a_ack_prefix : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      commit_ack_i[i] |-> commit_ack_i[i-1]);
  end

  a_ack_on_valid : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (commit_ack_i & ~commit_valid) == '0);

  for (genvar k = 0; k < NR_WB_PORTS; k++) begin : g_wb_k
    for (genvar j = k + 1; j < NR_WB_PORTS; j++) begin : g_wb_j
      a_wb_unique : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(wb_valid_i[k] && wb_valid_i[j] && (wb_trans_id_i[k] == wb_trans_id_i[j])));
    end
  end

endmodule

// File: tb/tb_retire_rob.sv
module tb_retire_rob;
  import retire_rob_pkg::*;

  localparam int NE = 8;
  localparam int NW = 4;
  localparam int NC = 2;

  logic                                   clk_i = 1'b0;
  logic                                   rst_i;
  logic                                   flush_i;
  logic                                   issue_valid_i;
  logic                                   issue_ready_o;
  scoreboard_entry_t                      issue_instr_i;
  logic [TRANS_ID_BITS-1:0]               issue_trans_id_o;
  logic [NW-1:0]                          wb_valid_i;
  logic [NW-1:0][TRANS_ID_BITS-1:0]       wb_trans_id_i;
  logic [NW-1:0][XLEN-1:0]                wb_data_i;
  exception_t [NW-1:0]                    wb_ex_i;
  scoreboard_entry_t [NC-1:0]             commit_instr_o;
  logic [NC-1:0]                          commit_ack_i;
  logic                                   rob_empty_o;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic            exv;
    logic [XLEN-1:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  retire_rob #(
    .NR_ENTRIES     (NE),
    .NR_WB_PORTS    (NW),
    .NR_COMMIT_PORTS(NC)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_instr_i   (issue_instr_i),
    .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i      (wb_valid_i),
    .wb_trans_id_i   (wb_trans_id_i),
    .wb_data_i       (wb_data_i),
    .wb_ex_i         (wb_ex_i),
    .commit_instr_o  (commit_instr_o),
    .commit_ack_i    (commit_ack_i),
    .rob_empty_o     (rob_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    wb_valid_i    = '0;
    commit_ack_i  = '0;
    flush_i       = 1'b0;
  endtask

  task automatic set_issue(input logic [XLEN-1:0] pc, input logic exv, input logic [XLEN-1:0] cause);
    issue_instr_i          = '0;
    issue_instr_i.pc       = pc;
    issue_instr_i.fu       = FU_ALU;
    issue_instr_i.rd       = pc[6:2];
    issue_instr_i.ex.valid = exv;
    issue_instr_i.ex.cause = cause;
    issue_valid_i          = 1'b1;
  endtask

  task automatic set_wb(input int k, input logic [TRANS_ID_BITS-1:0] id, input logic [XLEN-1:0] data,
                        input logic exv, input logic [XLEN-1:0] cause);
    wb_valid_i[k]       = 1'b1;
    wb_trans_id_i[k]    = id;
    wb_data_i[k]        = data;
    wb_ex_i[k]          = '0;
    wb_ex_i[k].valid    = exv;
    wb_ex_i[k].cause    = cause;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] res,
                      input logic exv, input logic [XLEN-1:0] cause);
    exp_t e;
    e.pc = pc; e.result = res; e.exv = exv; e.cause = cause;
    exp_q.push_back(e);
  endtask

  // Monitor: every retiring port (valid & ack) is checked against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int i = 0; i < NC; i++) begin
        if (commit_ack_i[i] && commit_instr_o[i].valid) begin
          if (exp_q.size() == 0) begin
            check("retire_unexpected", commit_instr_o[i].pc, '0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("retire_pc",     commit_instr_o[i].pc,       e.pc);
            check("retire_result", commit_instr_o[i].result,   e.result);
            check("retire_exv",    commit_instr_o[i].ex.valid, e.exv);
            check("retire_cause",  commit_instr_o[i].ex.cause, e.cause);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i         = 1'b1;
    issue_instr_i = '0;
    wb_trans_id_i = '0;
    wb_data_i     = '0;
    wb_ex_i       = '0;
    idle();

    // 1 Reset
    repeat (2) tick();
    rst_i = 1'b0;
    check("rst_ready",    issue_ready_o, 1);
    check("rst_trans_id", issue_trans_id_o, 0);
    check("rst_empty",    rob_empty_o, 1);
    check("rst_valid0",   commit_instr_o[0].valid, 0);
    check("rst_valid1",   commit_instr_o[1].valid, 0);

    // 2 Out-of-order writeback
    set_issue(32'h100, 0, 0); push(32'h100, 32'h11, 0, 0); tick();
    set_issue(32'h104, 0, 0); push(32'h104, 32'h22, 0, 0); tick();
    set_issue(32'h108, 0, 0); push(32'h108, 32'h33, 0, 0); tick();
    idle();
    check("ooo_trans_id", issue_trans_id_o, 3);
    check("ooo_empty", rob_empty_o, 0);
    set_wb(0, 2, 32'h33, 0, 0); tick(); idle();
    check("ooo_wb2_valid0", commit_instr_o[0].valid, 0);
    set_wb(1, 1, 32'h22, 0, 0); tick(); idle();
    check("ooo_wb1_valid0", commit_instr_o[0].valid, 0);
    check("ooo_wb1_valid1", commit_instr_o[1].valid, 0);
    set_wb(2, 0, 32'h11, 0, 0); tick(); idle();
    check("ooo_wb0_valid0", commit_instr_o[0].valid, 1);
    check("ooo_wb0_valid1", commit_instr_o[1].valid, 1);
    check("ooo_port0_res", commit_instr_o[0].result, 32'h11);
    check("ooo_port1_res", commit_instr_o[1].result, 32'h22);
    commit_ack_i = 2'b11; tick(); idle();
    check("ooo_head_pc",  commit_instr_o[0].pc, 32'h108);
    check("ooo_c_valid",  commit_instr_o[0].valid, 1);
    check("ooo_c_res",    commit_instr_o[0].result, 32'h33);
    commit_ack_i = 2'b01; tick(); idle();
    check("ooo_empty_end", rob_empty_o, 1);

    // 3 Full and wrap, from a fresh reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("full_rst_trans_id", issue_trans_id_o, 0);
    for (int i = 0; i < NE; i++) begin
      set_issue(32'h200 + 32'(4*i), 0, 0);
      push(32'h200 + 32'(4*i), 32'h1000 + 32'(i), 0, 0);
      tick();
    end
    idle();
    check("full_ready", issue_ready_o, 0);
    check("full_trans_id", issue_trans_id_o, 0);
    set_wb(0, 0, 32'h1000, 0, 0); tick(); idle();
    commit_ack_i = 2'b01;
    set_issue(32'h300, 0, 0);
    check("full_ready_at_commit", issue_ready_o, 0);
    tick(); idle();
    check("full_ready_after", issue_ready_o, 1);
    check("full_rejected_id", issue_trans_id_o, 0);
    set_issue(32'h300, 0, 0); push(32'h300, 32'h2000, 0, 0); tick(); idle();
    check("full_accept_id", issue_trans_id_o, 1);
    check("full_again", issue_ready_o, 0);
    for (int k = 0; k < 4; k++) set_wb(k, TRANS_ID_BITS'(k + 1), 32'h1000 + 32'(k + 1), 0, 0);
    tick(); idle();
    for (int k = 0; k < 3; k++) set_wb(k, TRANS_ID_BITS'(k + 5), 32'h1000 + 32'(k + 5), 0, 0);
    set_wb(3, 0, 32'h2000, 0, 0);
    tick(); idle();
    for (int r = 0; r < 3; r++) begin
      commit_ack_i = 2'b11; tick();
    end
    idle();
    check("wrap_port0_pc", commit_instr_o[0].pc, 32'h21C);
    check("wrap_port1_pc", commit_instr_o[1].pc, 32'h300);
    check("wrap_port1_valid", commit_instr_o[1].valid, 1);
    commit_ack_i = 2'b11; tick(); idle();
    check("wrap_empty", rob_empty_o, 1);
    check("wrap_trans_id", issue_trans_id_o, 1);

    // 4 Issue-time exception, later overridden by writeback exception
    set_issue(32'h400, 1, 2); push(32'h400, 32'h55, 1, 5); tick(); idle();
    check("ex_valid0", commit_instr_o[0].valid, 1);
    check("ex_issue_cause", commit_instr_o[0].ex.cause, 2);
    check("ex_issue_exv", commit_instr_o[0].ex.valid, 1);
    set_wb(3, 1, 32'h55, 1, 5); tick(); idle();
    check("ex_wb_cause", commit_instr_o[0].ex.cause, 5);
    check("ex_wb_result", commit_instr_o[0].result, 32'h55);
    commit_ack_i = 2'b01; tick(); idle();
    check("ex_empty", rob_empty_o, 1);

    // 5 Flush with concurrent writeback and ack
    for (int i = 0; i < 5; i++) begin
      set_issue(32'h500 + 32'(4*i), 0, 0); tick();
    end
    idle();
    set_wb(0, 2, 32'hAA, 0, 0); tick(); idle();
    check("flush_pre_valid0", commit_instr_o[0].valid, 1);
    flush_i = 1'b1; set_wb(1, 3, 32'hBB, 0, 0); commit_ack_i = 2'b01;
    tick(); idle();
    check("flush_empty", rob_empty_o, 1);
    check("flush_trans_id", issue_trans_id_o, 0);
    check("flush_ready", issue_ready_o, 1);
    check("flush_valid0", commit_instr_o[0].valid, 0);
    set_wb(0, 3, 32'hCC, 0, 0); tick(); idle();
    check("stale_wb_empty", rob_empty_o, 1);
    check("stale_wb_valid0", commit_instr_o[0].valid, 0);

    // 6 Prefix commit
    set_issue(32'h600, 0, 0); push(32'h600, 32'h60, 0, 0); tick();
    set_issue(32'h604, 0, 0); push(32'h604, 32'h61, 0, 0); tick();
    idle();
    check("pfx_not_done", commit_instr_o[0].valid, 0);
    set_wb(0, 0, 32'h60, 0, 0); tick(); idle();
    check("pfx_valid0", commit_instr_o[0].valid, 1);
    check("pfx_valid1", commit_instr_o[1].valid, 0);
    commit_ack_i = 2'b01; tick(); idle();
    check("pfx_not_empty", rob_empty_o, 0);
    check("pfx_head1_valid", commit_instr_o[0].valid, 0);
    check("pfx_head1_pc", commit_instr_o[0].pc, 32'h604);
    set_wb(0, 1, 32'h61, 0, 0); tick(); idle();
    check("pfx_valid0_b", commit_instr_o[0].valid, 1);
    commit_ack_i = 2'b01; tick(); idle();
    check("pfx_empty", rob_empty_o, 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
